cpu_control: RTL
================

Name: cpu_control

Overview:
- Multi-cycle control unit sitting directly upstream of the 16-bit ALU.
- Fetches instructions over a req/ack handshake, decodes them, and drives the ALU operation code, operand select, register-file addresses/write enable and data-memory handshake.
- Latches the ALU Carry/isZero outputs into a flag register that steers conditional branches.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_OPCODE, 4'hF, opcode that enters the terminal HALT state.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  16  instruction address (= pc).
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch data valid this cycle.
- imem_rdata  in  16  fetched instruction.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req.
- dmem_ack  in  1  data access complete this cycle.
- rf_ra1  out  3  register read address A (rs).
- rf_ra2  out  3  register read address B (rt for R-type, rd for SW).
- rf_wa  out  3  write address (rd).
- rf_we  out  1  register write strobe (one cycle).
- rf_wsel  out  1  write data select: 0 = ALU_Out, 1 = memory read data.
- alu_code  out  3  ALU operation code.
- alu_b_imm  out  1  ALU B operand select: 1 = imm_ext, 0 = register B.
- imm_ext  out  16  sign-extended imm6.
- alu_carry  in  1  ALU Carry.
- alu_zero  in  1  ALU isZero.
- flag_c  out  1  latched carry flag.
- flag_z  out  1  latched zero flag.
- halted  out  1  high in HALT state.

Behaviour:
- Reset (async): state=FETCH, pc=RESET_PC, ir=0, flag_c=0, flag_z=0.
- Reset values of the strobes: imem_req, dmem_req, rf_we, halted, alu_b_imm, rf_wsel, dmem_we all 0. Reset mid-transaction drops requests immediately.
- Instruction format:
  - opcode [15:12], rd [11:9], rs [8:6], rt [5:3], imm6 [5:0].
  - imm12 [11:0] for JMP, zero-extended.
- Opcodes:
  - 0x0-0x7 R-type: rd <= rs op rt, alu_code = opcode[2:0].
  - 0x8 ADDI: rd <= rs + imm_ext.
  - 0x9 LW: rd <= mem[rs+imm_ext].
  - 0xA SW: mem[rs+imm_ext] <= rd.
  - 0xB BZ: branch if flag_z.
  - 0xC JMP: pc <= imm12.
  - 0xD/0xE: NOP.
  - 0xF: HALT.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - imem_req=1; hold until imem_ack.
  - On ack: ir <= imem_rdata, pc <= pc+1 (mod 2^16), then go to DECODE.
- DECODE (1 cycle): rf_ra1/ra2 valid. HALT_OPCODE -> HALT; NOP -> FETCH; all others -> EXEC.
- EXEC (1 cycle):
  - alu_code and alu_b_imm valid. ADDI/LW/SW use alu_code=000 and alu_b_imm=1.
  - R-type/ADDI: flag_c <= alu_carry, flag_z <= alu_zero, then -> WB.
  - LW/SW: -> MEM; flags unchanged.
  - BZ: if flag_z (value before this instruction), pc <= pc + imm_ext (wraps mod 2^16); -> FETCH.
  - JMP: pc <= {4'b0, imm12}; -> FETCH.
- MEM: dmem_req=1, dmem_we=(SW), held until dmem_ack. LW -> WB; SW -> FETCH. An ack arriving in the same cycle the request is raised completes the access.
- WB (1 cycle): rf_we=1, rf_wa=rd, rf_wsel=(LW); -> FETCH.
- HALT: terminal; only reset exits; halted=1, no requests issued.
- Address, code and select outputs are decoded from ir and held stable for EXEC through WB.
- Latency with zero-wait acks:
  - R-type/ADDI 4 cycles; LW 5; SW 4; BZ/JMP 3; NOP 2.
  - Each wait cycle adds one.

Decomposition:
- Shared package (cpu_pkg):
  - opcode constants.
  - ALU code constants (ADD=000 ... XOR=111).
  - state encoding.
  - instruction field bit positions.
- One natural sub-module: cpu_decoder, combinational ir -> control fields (alu_code, alu_b_imm, rf addresses, imm_ext, instruction class).
- FSM, pc and flag registers stay in cpu_control.

Test Plan:
- Reset then ADD r1,r2,r3 (16'h0298), acks immediate, alu_zero=0 -> imem_req in cycle 1, alu_code=000 in EXEC, rf_we=1 with rf_wa=1 in cycle 4, pc=1.
- SUB with alu_zero=1, alu_carry=1 driven in EXEC, then BZ imm6=6'h3E (-2) at pc=1 -> flag_z=1, pc becomes 0; BZ with flag_z=0 leaves pc=2.
- LW r4,[r5+3] with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, rf_wsel=1, rf_we one cycle after ack.
- imem_ack delayed 5 cycles -> imem_req held constant, imem_addr stable, ir loaded only on the ack cycle.
- JMP 12'hFFF -> pc=16'h0FFF; fetch at pc=16'hFFFF -> pc wraps to 16'h0000.
- 16'hF000 -> halted=1 after DECODE, no further requests; reset asserted mid-MEM -> dmem_req drops the same cycle, pc=RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants, field positions and encodings for the control unit
//
// Purpose : opcode values, ALU code for address/immediate arithmetic,
//           instruction field bit positions, FSM state and instruction
//           class encodings, and the imm6 sign-extension helper.
// Ports   : none (package).
package cpu_pkg;

  // Instruction field bit positions
  localparam int OP_HI    = 15;
  localparam int OP_LO    = 12;
  localparam int RD_HI    = 11;
  localparam int RD_LO    = 9;
  localparam int RS_HI    = 8;
  localparam int RS_LO    = 6;
  localparam int RT_HI    = 5;
  localparam int RT_LO    = 3;
  localparam int IMM6_HI  = 5;
  localparam int IMM6_LO  = 0;
  localparam int IMM12_HI = 11;

  // Opcodes 0x0-0x7 are R-type; 0xD/0xE fall through to NOP in the decoder
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LW   = 4'h9;
  localparam logic [3:0] OP_SW   = 4'hA;
  localparam logic [3:0] OP_BZ   = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  // ALU codes run ADD=000 through XOR=111; R-type passes opcode[2:0] straight
  // through, so only ADD is needed by name (ADDI and address generation).
  localparam logic [2:0] ALU_ADD = 3'b000;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_ADDI,
    CLS_LW,
    CLS_SW,
    CLS_BZ,
    CLS_JMP,
    CLS_NOP,
    CLS_HALT
  } iclass_t;

  function automatic logic [15:0] sext6(input logic [5:0] v);
    return {{10{v[5]}}, v};
  endfunction

endpackage

// File: rtl/cpu_decoder.sv
// rtl/cpu_decoder.sv - combinational instruction decoder
//
// Purpose : maps the instruction register to control fields.
// Ports   : ir         in  16  latched instruction
//           iclass     out 3   instruction class (iclass_t encoding)
//           alu_code   out 3   ALU operation code
//           alu_b_imm  out 1   1 = ALU B from imm_ext
//           ra1/ra2/wa out 3   register-file read/write addresses
//           imm_ext    out 16  sign-extended imm6
//           jmp_target out 16  zero-extended imm12
module cpu_decoder
  import cpu_pkg::*;
#(
  parameter logic [3:0] HALT_OPCODE = OP_HALT
) (
  input  logic [15:0] ir,
  output logic [2:0]  iclass,
  output logic [2:0]  alu_code,
  output logic        alu_b_imm,
  output logic [2:0]  ra1,
  output logic [2:0]  ra2,
  output logic [2:0]  wa,
  output logic [15:0] imm_ext,
  output logic [15:0] jmp_target
);

  logic [3:0] opcode;
  logic [2:0] rd;
  logic [2:0] rs;
  logic [2:0] rt;

  assign opcode = ir[OP_HI:OP_LO];
  assign rd     = ir[RD_HI:RD_LO];
  assign rs     = ir[RS_HI:RS_LO];
  assign rt     = ir[RT_HI:RT_LO];

  // HALT_OPCODE is checked first so a relocated halt opcode overrides its
  // normal meaning; anything unrecognised behaves as a NOP.
  always_comb begin
    iclass = CLS_NOP;
    if (opcode == HALT_OPCODE) begin
      iclass = CLS_HALT;
    end else if (!opcode[3]) begin
      iclass = CLS_RTYPE;
    end else begin
      case (opcode)
        OP_ADDI: iclass = CLS_ADDI;
        OP_LW:   iclass = CLS_LW;
        OP_SW:   iclass = CLS_SW;
        OP_BZ:   iclass = CLS_BZ;
        OP_JMP:  iclass = CLS_JMP;
        default: iclass = CLS_NOP;
      endcase
    end
  end

  assign alu_code   = (iclass == CLS_RTYPE) ? opcode[2:0] : ALU_ADD;
  assign alu_b_imm  = (iclass == CLS_ADDI) || (iclass == CLS_LW) || (iclass == CLS_SW);
  assign ra1        = rs;
  // SW reads the store data from rd through port B
  assign ra2        = (iclass == CLS_SW) ? rd : rt;
  assign wa         = rd;
  assign imm_ext    = sext6(ir[IMM6_HI:IMM6_LO]);
  assign jmp_target = {4'b0000, ir[IMM12_HI:0]};

endmodule

// File: rtl/cpu_control.sv
// rtl/cpu_control.sv - multi-cycle control unit driving the 16-bit ALU
//
// Purpose : fetch/decode/execute FSM with pc, instruction and flag registers.
// Ports   : clk, reset (async, active high)
//           imem_addr/imem_req/imem_ack/imem_rdata  instruction fetch handshake
//           dmem_req/dmem_we/dmem_ack               data memory handshake
//           rf_ra1/rf_ra2/rf_wa/rf_we/rf_wsel        register-file control
//           alu_code/alu_b_imm/imm_ext               ALU control
//           alu_carry/alu_zero                       ALU status inputs
//           flag_c/flag_z                            latched ALU flags
//           halted                                   terminal HALT indicator
module cpu_control
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = OP_HALT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic [2:0]  rf_ra1,
  output logic [2:0]  rf_ra2,
  output logic [2:0]  rf_wa,
  output logic        rf_we,
  output logic        rf_wsel,
  output logic [2:0]  alu_code,
  output logic        alu_b_imm,
  output logic [15:0] imm_ext,
  input  logic        alu_carry,
  input  logic        alu_zero,
  output logic        flag_c,
  output logic        flag_z,
  output logic        halted
);

  state_t      state, state_nx;
  logic [15:0] pc, pc_nx;
  logic [15:0] ir, ir_nx;
  logic        fc_nx, fz_nx;
  logic [2:0]  iclass;
  logic [15:0] jmp_target;

  cpu_decoder #(
    .HALT_OPCODE(HALT_OPCODE)
  ) u_dec (
    .ir        (ir),
    .iclass    (iclass),
    .alu_code  (alu_code),
    .alu_b_imm (alu_b_imm),
    .ra1       (rf_ra1),
    .ra2       (rf_ra2),
    .wa        (rf_wa),
    .imm_ext   (imm_ext),
    .jmp_target(jmp_target)
  );

  assign imem_addr = pc;
  // ir resets to an R-type word, so this is low out of reset
  assign rf_wsel   = (iclass == CLS_LW);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_FETCH;
      pc     <= RESET_PC;
      ir     <= 16'h0000;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      state  <= state_nx;
      pc     <= pc_nx;
      ir     <= ir_nx;
      flag_c <= fc_nx;
      flag_z <= fz_nx;
    end
  end

  // Strobes are decoded from state and additionally gated by reset so that
  // every request drops in the same cycle reset is raised.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    ir_nx    = ir;
    fc_nx    = flag_c;
    fz_nx    = flag_z;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    halted   = 1'b0;
    if (!reset) begin
      case (state)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_nx    = imem_rdata;
            pc_nx    = pc + 16'd1;
            state_nx = ST_DECODE;
          end
        end
        ST_DECODE: begin
          case (iclass)
            CLS_HALT: state_nx = ST_HALT;
            CLS_NOP:  state_nx = ST_FETCH;
            default:  state_nx = ST_EXEC;
          endcase
        end
        ST_EXEC: begin
          case (iclass)
            CLS_RTYPE, CLS_ADDI: begin
              fc_nx    = alu_carry;
              fz_nx    = alu_zero;
              state_nx = ST_WB;
            end
            CLS_LW, CLS_SW: state_nx = ST_MEM;
            CLS_BZ: begin
              // pc already points past the branch, so the offset is relative to pc+1
              if (flag_z) pc_nx = pc + imm_ext;
              state_nx = ST_FETCH;
            end
            CLS_JMP: begin
              pc_nx    = jmp_target;
              state_nx = ST_FETCH;
            end
            default: state_nx = ST_FETCH;
          endcase
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (iclass == CLS_SW);
          if (dmem_ack) state_nx = (iclass == CLS_SW) ? ST_FETCH : ST_WB;
        end
        ST_WB: begin
          rf_we    = 1'b1;
          state_nx = ST_FETCH;
        end
        ST_HALT: begin
          halted = 1'b1;
        end
        default: state_nx = ST_FETCH;
      endcase
    end
  end

endmodule
